// File: rtl/soc_dma_pkg.sv
// Shared definitions for the soc memory-to-memory DMA initiator:
// FSM state encoding and bus write-strobe constants.
package soc_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RGAP,
        WR,
        WGAP,
        DONE
    } dma_state_t;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_WORD = 4'hF;

endpackage

// File: rtl/soc_mem_dma.sv
// Word-copy DMA initiator on the soc valid/ready memory bus (read, gap, write, gap per word).
// Optional macro SOC_DMA_FILL_EN adds a fill mode that writes a constant without reading.
module soc_mem_dma
    import soc_dma_pkg::*;
#(
    parameter int AW = 10,
    parameter int LW = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
`ifdef SOC_DMA_FILL_EN
    input  logic          fill,
    input  logic [31:0]   fill_data,
`endif
    output logic          busy,
    output logic          done,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata
);

    dma_state_t    state_q, state_d;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] rem_q;
    logic [31:0]   wdata_q;
    logic          fill_mode;
    logic          fill_req;

`ifdef SOC_DMA_FILL_EN
    logic fill_q;
    assign fill_mode = fill_q;
    assign fill_req  = fill;
`else
    assign fill_mode = 1'b0;
    assign fill_req  = 1'b0;
`endif

    assign mem_wdata = wdata_q;

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = WSTRB_READ;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0)    state_d = DONE;
                    else if (fill_req) state_d = WR;
                    else               state_d = RD;
                end
            end
            RD: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_addr  = src_q;
                if (mem_ready) state_d = RGAP;
            end
            // Gap cycles ignore mem_ready: the responder may re-ack here.
            RGAP: begin
                busy    = 1'b1;
                state_d = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_wstrb = WSTRB_WORD;
                mem_addr  = dst_q;
                if (mem_ready) state_d = WGAP;
            end
            WGAP: begin
                busy = 1'b1;
                if (rem_q == '0)    state_d = DONE;
                else if (fill_mode) state_d = RGAP;
                else                state_d = RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
`ifdef SOC_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start && len != '0) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                rem_q <= len;
`ifdef SOC_DMA_FILL_EN
                fill_q <= fill;
                if (fill) wdata_q <= fill_data;
`endif
            end
            if (state_q == RD && mem_ready) wdata_q <= mem_rdata;
            // Address counters wrap naturally modulo 2^AW.
            if (state_q == WR && mem_ready) begin
                rem_q <= rem_q - LW'(1);
                src_q <= src_q + AW'(1);
                dst_q <= dst_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_mem_dma.sv
// Directed testbench for soc_mem_dma with a behavioural memory responder of programmable latency.
module tb_soc_mem_dma;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
`ifdef SOC_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    soc_mem_dma #(.AW(10), .LW(11)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
`ifdef SOC_DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .busy      (busy),
        .done      (done),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    // Responder: acks lat cycles after valid is first seen (lat=1 is zero-wait).
    logic [31:0] mem [0:1023];
    logic [9:0]  rd_log [0:63];
    logic [9:0]  wr_log [0:63];
    int          lat = 1;
    int          wcnt = 0;
    int          nr = 0;
    int          nw = 0;
    int          vcnt = 0;
    int          viol = 0;
    logic        pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [9:0]  pa = '0;
    logic [31:0] pd = '0;
    logic [3:0]  ps = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            wcnt      <= 0;
        end else if (mem_valid && !mem_ready) begin
            if (wcnt + 1 >= lat) begin
                mem_ready <= 1'b1;
                wcnt      <= 0;
                if (mem_wstrb == 4'hF) begin
                    mem[mem_addr]   <= mem_wdata;
                    wr_log[nw % 64] <= mem_addr;
                    nw              <= nw + 1;
                end else begin
                    mem_rdata       <= mem[mem_addr];
                    rd_log[nr % 64] <= mem_addr;
                    nr              <= nr + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            mem_ready <= 1'b0;
        end
    end

    // Bus-protocol monitor: a pending request must stay asserted and unchanged.
    always @(posedge clk) begin
        if (mem_valid) vcnt <= vcnt + 1;
        if (prst && resetn && pv && !pr &&
            (!mem_valid || mem_addr != pa || mem_wdata != pd || mem_wstrb != ps))
            viol <= viol + 1;
        pv   <= mem_valid;
        pr   <= mem_ready;
        pa   <= mem_addr;
        pd   <= mem_wdata;
        ps   <= mem_wstrb;
        prst <= resetn;
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] v);
        mem[a] <= v;
    endtask

    task automatic do_start(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic run_to_done(output int bc, output bit seen);
        int g;
        bc = 0;
        g  = 0;
        while (done !== 1'b1 && g < 2000) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            g++;
        end
        seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (mem_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", mem_valid); end
        total++; if (mem_wstrb !== 4'h0)  begin bad++; $display("FAIL reset_wstrb got=%h want=0", mem_wstrb); end
        total++; if (mem_addr !== 10'h0)  begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        int bc; bit seen; int r0, w0;
        for (int i = 0; i < 4; i++) begin
            preload(10'h010 + 10'(i), 32'hA0 + 32'(i));
            preload(10'h200 + 10'(i), 32'h0);
        end
        r0 = nr; w0 = nw;
        do_start(10'h010, 10'h200, 11'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL copy_busy_rise got=%b want=1", busy); end
        run_to_done(bc, seen);
        total++; if (!seen)   begin bad++; $display("FAIL copy_done_timeout got=0 want=1"); end
        total++; if (bc != 24) begin bad++; $display("FAIL copy_cycles got=%0d want=24", bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL copy_busy_at_done got=%b want=0", busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL copy_done_pulse got=%b want=0", done); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[10'h200 + 10'(i)] !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL copy_data[%0d] got=%h want=%h", i, mem[10'h200 + 10'(i)], 32'hA0 + 32'(i));
            end
        end
        total++; if (nr - r0 != 4) begin bad++; $display("FAIL copy_reads got=%0d want=4", nr - r0); end
        total++; if (nw - w0 != 4) begin bad++; $display("FAIL copy_writes got=%0d want=4", nw - w0); end
    endtask

    task automatic test_zero_len();
        int bc; bit seen; int v0;
        v0 = vcnt;
        do_start(10'h010, 10'h210, 11'd0);
        run_to_done(bc, seen);
        total++; if (!seen)   begin bad++; $display("FAIL zero_done got=0 want=1"); end
        total++; if (bc != 0) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=0", bc); end
        @(negedge clk);
        total++; if (vcnt != v0) begin bad++; $display("FAIL zero_valid_count got=%0d want=0", vcnt - v0); end
    endtask

    task automatic test_wrap();
        int bc; bit seen; int r0, w0;
        preload(10'h3FF, 32'h1111_1111);
        preload(10'h000, 32'h2222_2222);
        r0 = nr; w0 = nw;
        do_start(10'h3FF, 10'h0FF, 11'd2);
        run_to_done(bc, seen);
        total++; if (!seen) begin bad++; $display("FAIL wrap_done got=0 want=1"); end
        total++; if (rd_log[r0 % 64] !== 10'h3FF)     begin bad++; $display("FAIL wrap_rd0 got=%h want=3ff", rd_log[r0 % 64]); end
        total++; if (rd_log[(r0 + 1) % 64] !== 10'h000) begin bad++; $display("FAIL wrap_rd1 got=%h want=000", rd_log[(r0 + 1) % 64]); end
        total++; if (wr_log[w0 % 64] !== 10'h0FF)     begin bad++; $display("FAIL wrap_wr0 got=%h want=0ff", wr_log[w0 % 64]); end
        total++; if (wr_log[(w0 + 1) % 64] !== 10'h100) begin bad++; $display("FAIL wrap_wr1 got=%h want=100", wr_log[(w0 + 1) % 64]); end
        total++; if (mem[10'h0FF] !== 32'h1111_1111) begin bad++; $display("FAIL wrap_data0 got=%h want=11111111", mem[10'h0FF]); end
        total++; if (mem[10'h100] !== 32'h2222_2222) begin bad++; $display("FAIL wrap_data1 got=%h want=22222222", mem[10'h100]); end
    endtask

    task automatic test_wait_states();
        int bc; bit seen; int w0;
        preload(10'h020, 32'h5555_AAAA);
        preload(10'h040, 32'h0);
        lat = 3;
        w0  = nw;
        do_start(10'h020, 10'h040, 11'd1);
        run_to_done(bc, seen);
        total++; if (!seen)    begin bad++; $display("FAIL wait_done got=0 want=1"); end
        total++; if (bc != 10) begin bad++; $display("FAIL wait_cycles got=%0d want=10", bc); end
        total++; if (nw - w0 != 1) begin bad++; $display("FAIL wait_writes got=%0d want=1", nw - w0); end
        total++; if (mem[10'h040] !== 32'h5555_AAAA) begin bad++; $display("FAIL wait_data got=%h want=5555aaaa", mem[10'h040]); end
        total++; if (viol != 0) begin bad++; $display("FAIL wait_stability got=%0d want=0", viol); end
        lat = 1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int bc, bc2; bit seen;
        preload(10'h380, 32'h0);
        preload(10'h381, 32'h0);
        preload(10'h3C0, 32'h0BAD_0BAD);
        do_start(10'h010, 10'h380, 11'd2);
        bc = 0;
        repeat (3) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
        end
        start = 1'b1; src_addr = 10'h013; dst_addr = 10'h3C0; len = 11'd1;
        if (busy === 1'b1) bc++;
        @(negedge clk);
        start = 1'b0;
        run_to_done(bc2, seen);
        total++; if (!seen) begin bad++; $display("FAIL ign_done got=0 want=1"); end
        total++; if (bc + bc2 != 12) begin bad++; $display("FAIL ign_cycles got=%0d want=12", bc + bc2); end
        total++; if (mem[10'h380] !== 32'hA0) begin bad++; $display("FAIL ign_data0 got=%h want=a0", mem[10'h380]); end
        total++; if (mem[10'h381] !== 32'hA1) begin bad++; $display("FAIL ign_data1 got=%h want=a1", mem[10'h381]); end
        total++; if (mem[10'h3C0] !== 32'h0BAD_0BAD) begin bad++; $display("FAIL ign_untouched got=%h want=0bad0bad", mem[10'h3C0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc, g; bit seen;
        for (int i = 0; i < 4; i++) preload(10'h300 + 10'(i), 32'h0);
        preload(10'h310, 32'h0);
        preload(10'h311, 32'h0);
        do_start(10'h010, 10'h300, 11'd4);
        g = 0;
        while (!(mem_valid === 1'b1 && mem_wstrb === 4'hF && mem_addr === 10'h301) && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++; if (g >= 200) begin bad++; $display("FAIL mid_reach_wr2 got=timeout want=WR of word 2"); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", mem_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL mid_addr got=%h want=0", mem_addr); end
        repeat (3) @(negedge clk);
        total++; if (mem[10'h302] !== 32'h0) begin bad++; $display("FAIL mid_no_word3 got=%h want=0", mem[10'h302]); end
        do_start(10'h012, 10'h310, 11'd2);
        run_to_done(bc, seen);
        total++; if (!seen)    begin bad++; $display("FAIL mid_restart_done got=0 want=1"); end
        total++; if (bc != 12) begin bad++; $display("FAIL mid_restart_cycles got=%0d want=12", bc); end
        total++; if (mem[10'h310] !== 32'hA2) begin bad++; $display("FAIL mid_restart_d0 got=%h want=a2", mem[10'h310]); end
        total++; if (mem[10'h311] !== 32'hA3) begin bad++; $display("FAIL mid_restart_d1 got=%h want=a3", mem[10'h311]); end
        @(negedge clk);
    endtask

`ifdef SOC_DMA_FILL_EN
    task automatic test_fill();
        int bc; bit seen; int r0;
        for (int i = 0; i < 3; i++) preload(10'h080 + 10'(i), 32'h0);
        r0 = nr;
        @(negedge clk);
        start = 1'b1; fill = 1'b1; fill_data = 32'hDEAD_BEEF;
        src_addr = 10'h010; dst_addr = 10'h080; len = 11'd3;
        @(negedge clk);
        start = 1'b0; fill = 1'b0; fill_data = 32'h0;
        run_to_done(bc, seen);
        total++; if (!seen) begin bad++; $display("FAIL fill_done got=0 want=1"); end
        total++; if (nr != r0) begin bad++; $display("FAIL fill_reads got=%0d want=0", nr - r0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[10'h080 + 10'(i)] !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL fill_data[%0d] got=%h want=deadbeef", i, mem[10'h080 + 10'(i)]);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
`ifdef SOC_DMA_FILL_EN
        fill      = 1'b0;
        fill_data = '0;
`endif
        test_reset();
        test_copy();
        test_zero_len();
        test_wrap();
        test_wait_states();
        test_start_ignored();
        test_reset_mid();
`ifdef SOC_DMA_FILL_EN
        test_fill();
`endif
        total++; if (viol != 0) begin bad++; $display("FAIL bus_stability got=%0d want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
